// File: rtl/present_pkg.sv
// present_pkg -- shared definitions for the PRESENT-80 encryptor.
//   SBOX_TABLE  : 4-bit S-box, entry for input n in bits [4n+3:4n]
//   ROUNDS      : number of full rounds (31)
//   state_t     : encryptor FSM states
//   sbox_lookup : table lookup helper used by present_sbox
//   p_layer     : PRESENT bit permutation (bit j -> 16*j mod 63, bit 63 fixed)
package present_pkg;

    localparam int unsigned ROUNDS = 31;

    // Inputs 0..F map to C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 (input 0 in the low nibble).
    localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] sbox_lookup(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int unsigned j = 0; j < 63; j++) begin
            r[6'((16 * j) % 63)] = s[6'(j)];
        end
        r[63] = s[63];
        return r;
    endfunction

endpackage

// File: rtl/present_sbox.sv
// present_sbox -- 4-bit combinational PRESENT S-box.
//   sbox_in  : 4-bit nibble
//   sbox_out : substituted nibble
module present_sbox
    import present_pkg::*;
(
    input  logic [3:0] sbox_in,
    output logic [3:0] sbox_out
);

    assign sbox_out = sbox_lookup(sbox_in);

endmodule

// File: rtl/present_encryptor_top.sv
// present_encryptor_top -- iterative PRESENT-80 block encryptor, one round per clock.
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous reset, active low
//   data_i    : 80-bit key (key_load) or plaintext in [63:0] (data_load)
//   key_load  : capture master key; wins over data_load
//   data_load : capture plaintext and (re)start an encryption
//   data_o    : ciphertext register
//   done_o    : data_o holds a valid ciphertext
// Build option: define PRESENT_OUT_MASK_EN to force data_o to zero while done_o is low.
// Timing: load edge, then 31 round edges, then the 32nd edge applies K32 and raises done_o.
module present_encryptor_top
    import present_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [79:0] data_i,
    input  logic        key_load,
    input  logic        data_load,
    output logic [63:0] data_o,
    output logic        done_o
);

    state_t      fsm;
    logic [63:0] state_q;
    logic [79:0] master_key;
    logic [79:0] work_key;
    logic [4:0]  round_q;
    logic [63:0] out_q;

    logic [63:0] round_in;
    logic [63:0] sbox_vec;
    logic [63:0] round_next;
    logic [79:0] key_rot;
    logic [3:0]  key_sb;
    logic [79:0] key_next;

    // Datapath for one round: add round key, substitute, permute.
    assign round_in = state_q ^ work_key[79:16];

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        present_sbox u_sbox (
            .sbox_in  (round_in[4*g +: 4]),
            .sbox_out (sbox_vec[4*g +: 4])
        );
    end

    assign round_next = p_layer(sbox_vec);

    // Key schedule: rotate left by 61, substitute top nibble, mix in round counter.
    assign key_rot = {work_key[18:0], work_key[79:19]};

    present_sbox u_key_sbox (
        .sbox_in  (key_rot[79:76]),
        .sbox_out (key_sb)
    );

    assign key_next = {key_sb, key_rot[75:20], key_rot[19:15] ^ round_q, key_rot[14:0]};

    // Master key is independent of the FSM so a running encryption keeps its working key.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            master_key <= '0;
        end else if (key_load) begin
            master_key <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm      <= ST_IDLE;
            state_q  <= '0;
            work_key <= '0;
            round_q  <= '0;
            out_q    <= '0;
            done_o   <= 1'b0;
        end else if (data_load && !key_load) begin
            // Start or abort-and-restart from any state.
            fsm      <= ST_RUN;
            state_q  <= data_i[63:0];
            work_key <= master_key;
            round_q  <= 5'd1;
            done_o   <= 1'b0;
        end else begin
            case (fsm)
                ST_RUN: begin
                    state_q  <= round_next;
                    work_key <= key_next;
                    if (round_q == 5'(ROUNDS)) begin
                        fsm <= ST_DONE;
                    end else begin
                        round_q <= round_q + 5'd1;
                    end
                end
                ST_DONE: begin
                    // First edge in DONE applies the final key; afterwards the result holds.
                    if (!done_o) begin
                        out_q  <= state_q ^ work_key[79:16];
                        done_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PRESENT_OUT_MASK_EN
    assign data_o = done_o ? out_q : '0;
`else
    assign data_o = out_q;
`endif

endmodule

// File: tb/tb_present_encryptor_top.sv
module tb_present_encryptor_top;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [79:0] data_i = '0;
    logic        key_load = 1'b0;
    logic        data_load = 1'b0;
    logic [63:0] data_o;
    logic        done_o;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    localparam logic [79:0] KEY_ZERO = 80'h0;
    localparam logic [79:0] KEY_ONES = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] PT_ZERO  = 64'h0;
    localparam logic [63:0] PT_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] CT_00    = 64'h5579_C138_7B22_8445;
    localparam logic [63:0] CT_10    = 64'hE72C_46C0_F594_5049;
    localparam logic [63:0] CT_01    = 64'hA112_FFC7_2F68_417B;
    localparam logic [63:0] CT_11    = 64'h3333_DCD3_2132_10D2;

    always #5 clk_i = ~clk_i;

    present_encryptor_top dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .data_i    (data_i),
        .key_load  (key_load),
        .data_load (data_load),
        .data_o    (data_o),
        .done_o    (done_o)
    );

    // Stimulus helpers (no checking): each returns on the falling edge after the load edge.
    task automatic load_key(input logic [79:0] k);
        @(negedge clk_i);
        data_i   = k;
        key_load = 1'b1;
        @(negedge clk_i);
        key_load = 1'b0;
    endtask

    task automatic load_data(input logic [63:0] p);
        @(negedge clk_i);
        data_i    = {16'hA5A5, p};
        data_load = 1'b1;
        @(negedge clk_i);
        data_load = 1'b0;
    endtask

    function automatic logic [63:0] running_view(input logic [63:0] held);
`ifdef PRESENT_OUT_MASK_EN
        return '0;
`else
        return held;
`endif
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (data_o !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected %h", data_o, 64'h0);
        end
        n_checks++;
        if (done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b expected 0", done_o);
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_vectors();
        logic [79:0] keys [4];
        logic [63:0] pts  [4];
        logic [63:0] cts  [4];
        logic [63:0] prev;
        keys = '{KEY_ZERO, KEY_ONES, KEY_ZERO, KEY_ONES};
        pts  = '{PT_ZERO,  PT_ZERO,  PT_ONES,  PT_ONES};
        cts  = '{CT_00,    CT_10,    CT_01,    CT_11};
        prev = 64'h0;
        for (int v = 0; v < 4; v++) begin
            load_key(keys[v]);
            load_data(pts[v]);
            for (int c = 1; c <= 31; c++) begin
                @(negedge clk_i);
                n_checks++;
                if (done_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL vec%0d_early_done cycle %0d: got %b expected 0", v, c, done_o);
                end
                if (c == 16) begin
                    n_checks++;
                    if (data_o !== running_view(prev)) begin
                        n_fail++;
                        $display("FAIL vec%0d_hold: got %h expected %h", v, data_o, running_view(prev));
                    end
                end
            end
            @(negedge clk_i);
            n_checks++;
            if (done_o !== 1'b1) begin
                n_fail++;
                $display("FAIL vec%0d_done: got %b expected 1", v, done_o);
            end
            n_checks++;
            if (data_o !== cts[v]) begin
                n_fail++;
                $display("FAIL vec%0d_data: got %h expected %h", v, data_o, cts[v]);
            end
            prev = cts[v];
        end
    endtask

    // Entered with done_o=1, ciphertext CT_11 and master key all-ones.
    task automatic test_both_loads();
        @(negedge clk_i);
        data_i    = KEY_ZERO;
        key_load  = 1'b1;
        data_load = 1'b1;
        @(negedge clk_i);
        key_load  = 1'b0;
        data_load = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (done_o !== 1'b1 || data_o !== CT_11) begin
                n_fail++;
                $display("FAIL both_loads_hold cycle %0d: got done=%b data=%h expected done=1 data=%h",
                         c, done_o, data_o, CT_11);
            end
            @(negedge clk_i);
        end
        load_data(PT_ZERO);
        repeat (32) @(negedge clk_i);
        n_checks++;
        if (done_o !== 1'b1 || data_o !== CT_00) begin
            n_fail++;
            $display("FAIL both_loads_key: got done=%b data=%h expected done=1 data=%h",
                     done_o, data_o, CT_00);
        end
    endtask

    // Master key is zero on entry; a mid-run key load must not disturb the current run.
    task automatic test_key_during_run();
        load_data(PT_ZERO);
        repeat (5) @(negedge clk_i);
        load_key(KEY_ONES);
        repeat (25) @(negedge clk_i);
        n_checks++;
        if (done_o !== 1'b1 || data_o !== CT_00) begin
            n_fail++;
            $display("FAIL key_mid_run: got done=%b data=%h expected done=1 data=%h",
                     done_o, data_o, CT_00);
        end
        load_data(PT_ZERO);
        repeat (32) @(negedge clk_i);
        n_checks++;
        if (done_o !== 1'b1 || data_o !== CT_10) begin
            n_fail++;
            $display("FAIL key_next_run: got done=%b data=%h expected done=1 data=%h",
                     done_o, data_o, CT_10);
        end
    endtask

    // Master key all-ones, last ciphertext CT_10 on entry.
    task automatic test_abort();
        load_data(PT_ZERO);
        repeat (10) @(negedge clk_i);
        load_data(PT_ONES);
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk_i);
            n_checks++;
            if (done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_early_done cycle %0d: got %b expected 0", c, done_o);
            end
        end
        n_checks++;
        if (data_o !== running_view(CT_10)) begin
            n_fail++;
            $display("FAIL abort_hold: got %h expected %h", data_o, running_view(CT_10));
        end
        @(negedge clk_i);
        n_checks++;
        if (done_o !== 1'b1 || data_o !== CT_11) begin
            n_fail++;
            $display("FAIL abort_result: got done=%b data=%h expected done=1 data=%h",
                     done_o, data_o, CT_11);
        end
    endtask

    task automatic test_reset_mid_run();
        load_data(PT_ZERO);
        repeat (10) @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (data_o !== 64'h0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got done=%b data=%h expected done=0 data=%h",
                     done_o, data_o, 64'h0);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (40) @(negedge clk_i);
        n_checks++;
        if (done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_resume: got %b expected 0", done_o);
        end
        load_data(PT_ZERO);
        repeat (32) @(negedge clk_i);
        n_checks++;
        if (done_o !== 1'b1 || data_o !== CT_00) begin
            n_fail++;
            $display("FAIL reset_rerun: got done=%b data=%h expected done=1 data=%h",
                     done_o, data_o, CT_00);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_both_loads();
        test_key_during_run();
        test_abort();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
